// File: rtl/instr_mem_banked.sv
// rtl/instr_mem_banked.sv - banked instruction store with fault-checked fetch port and burst loader
// Optional feature macro: INSTR_MEM_PARITY_EN (per-word even parity, adds parity_err output).
module instr_mem_banked #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int NUM_BANKS      = 4,
    parameter int BANK_SEL_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_en,
    input  logic [DATA_WIDTH-1:0]     fetch_addr,
    input  logic                      mode,
    input  logic [BANK_SEL_WIDTH-1:0] user_bank,
    output logic [DATA_WIDTH-1:0]     instr_out,
    output logic                      instr_valid,
    output logic                      fetch_fault,
`ifdef INSTR_MEM_PARITY_EN
    output logic                      parity_err,
`endif
    input  logic                      load_start,
    input  logic [BANK_SEL_WIDTH-1:0] load_bank,
    input  logic [ADDR_WIDTH-1:0]     load_base,
    input  logic [ADDR_WIDTH:0]       load_len,
    input  logic [DATA_WIDTH-1:0]     load_data,
    input  logic                      load_valid,
    output logic                      load_ready,
    output logic                      load_busy,
    output logic                      load_done,
    output logic [ADDR_WIDTH:0]       load_count
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int NSEL  = 2**BANK_SEL_WIDTH;
`ifdef INSTR_MEM_PARITY_EN
    localparam int WW = DATA_WIDTH + 1;
`else
    localparam int WW = DATA_WIDTH;
`endif
    // One bit per selector value: set when that bank is implemented.
    localparam logic [NSEL-1:0] BANK_EXISTS = {NSEL{1'b1}} >> (NSEL - NUM_BANKS);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                    state, state_next;
    logic [BANK_SEL_WIDTH-1:0] ld_bank;
    logic [ADDR_WIDTH-1:0]     ld_base;
    logic [ADDR_WIDTH:0]       ld_len;
    logic                      start_ok;
    logic                      wr_en;
    logic [ADDR_WIDTH:0]       count_inc;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [WW-1:0]             wr_word;

    logic [WW-1:0] mem [NUM_BANKS][DEPTH];

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        wr_en      = 1'b0;
        count_inc  = load_count + (ADDR_WIDTH+1)'(1);
        wr_addr    = ld_base + load_count[ADDR_WIDTH-1:0];
        case (state)
            IDLE: begin
                if (load_start && BANK_EXISTS[load_bank]) begin
                    start_ok   = 1'b1;
                    state_next = (load_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    wr_en = 1'b1;
                    if (count_inc == ld_len)
                        state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ld_bank    <= '0;
            ld_base    <= '0;
            ld_len     <= '0;
            load_count <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                ld_bank    <= load_bank;
                ld_base    <= load_base;
                ld_len     <= load_len;
                load_count <= '0;
            end else if (wr_en) begin
                load_count <= count_inc;
            end
        end
    end

    assign load_ready = (state == LOAD);
    assign load_busy  = (state != IDLE);
    assign load_done  = (state == DONE);

`ifdef INSTR_MEM_PARITY_EN
    assign wr_word = {^load_data, load_data};
`else
    assign wr_word = load_data;
`endif

    // Storage is deliberately outside the reset domain so images survive rst.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[ld_bank][wr_addr] <= wr_word;
    end

    logic [BANK_SEL_WIDTH-1:0] sel_bank;
    logic [WW-1:0]             rd_word;
    logic                      base_fault;
    logic                      par_fault;
    logic                      fault;

    always_comb begin
        sel_bank   = mode ? user_bank : '0;
        rd_word    = mem[sel_bank][fetch_addr[ADDR_WIDTH-1:0]];
        base_fault = (|fetch_addr[DATA_WIDTH-1:ADDR_WIDTH])
                   | (mode & (user_bank == '0))
                   | ~BANK_EXISTS[sel_bank]
                   | (load_busy & (sel_bank == ld_bank));
`ifdef INSTR_MEM_PARITY_EN
        par_fault  = ^rd_word;
`else
        par_fault  = 1'b0;
`endif
        fault      = base_fault | par_fault;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_out   <= '0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else if (fetch_en) begin
            instr_valid <= 1'b1;
            fetch_fault <= fault;
            instr_out   <= fault ? '0 : rd_word[DATA_WIDTH-1:0];
`ifdef INSTR_MEM_PARITY_EN
            parity_err  <= par_fault & ~base_fault;
`endif
        end else begin
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_instr_mem_banked.sv
// tb/tb_instr_mem_banked.sv - directed self-checking bench for instr_mem_banked
// Parity checks are compiled in when INSTR_MEM_PARITY_EN is defined.
module tb_instr_mem_banked;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_en = 1'b0;
    logic [DW-1:0] fetch_addr = '0;
    logic          mode = 1'b0;
    logic [BW-1:0] user_bank = '0;
    logic [DW-1:0] instr_out;
    logic          instr_valid;
    logic          fetch_fault;
`ifdef INSTR_MEM_PARITY_EN
    logic          parity_err;
`endif
    logic          load_start = 1'b0;
    logic [BW-1:0] load_bank = '0;
    logic [AW-1:0] load_base = '0;
    logic [AW:0]   load_len = '0;
    logic [DW-1:0] load_data = '0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic          load_busy;
    logic          load_done;
    logic [AW:0]   load_count;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] ldw [8];
    int rdy_cyc;
    int done_cyc;

    instr_mem_banked dut (
        .clk(clk), .rst(rst),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr), .mode(mode), .user_bank(user_bank),
        .instr_out(instr_out), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
`ifdef INSTR_MEM_PARITY_EN
        .parity_err(parity_err),
`endif
        .load_start(load_start), .load_bank(load_bank), .load_base(load_base),
        .load_len(load_len), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .load_busy(load_busy), .load_done(load_done),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input string tag, input logic m, input logic [BW-1:0] ub,
                            input logic [DW-1:0] addr, input logic exp_fault, input logic [DW-1:0] exp_data);
        @(negedge clk);
        fetch_en = 1'b1; mode = m; user_bank = ub; fetch_addr = addr;
        @(negedge clk);
        fetch_en = 1'b0;
        check({tag, ".valid"}, instr_valid, 1'b1);
        check({tag, ".fault"}, fetch_fault, exp_fault);
        check({tag, ".data"}, instr_out, exp_data);
    endtask

    task automatic do_load(input logic [BW-1:0] b, input logic [AW-1:0] base, input logic [AW:0] len,
                           input bit toggle, output int rdy, output int done);
        int idx;
        idx = 0; rdy = 0; done = 0;
        @(negedge clk);
        load_start = 1'b1; load_bank = b; load_base = base; load_len = len;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            load_start = 1'b0;
            if (load_ready) rdy++;
            if (load_done) done++;
            load_valid = load_ready && (!toggle || c[0]);
            load_data = ldw[idx & 7];
            if (load_valid) idx++;
        end
        load_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst.instr_out", instr_out, '0);
        check("rst.instr_valid", instr_valid, 1'b0);
        check("rst.fetch_fault", fetch_fault, 1'b0);
        check("rst.load_ready", load_ready, 1'b0);
        check("rst.load_busy", load_busy, 1'b0);
        check("rst.load_done", load_done, 1'b0);
        check("rst.load_count", {21'd0, load_count}, '0);
        rst = 1'b0;

        // Kernel image into bank 0.
        ldw[0] = 32'h7000_0000; ldw[1] = 32'h9400_0000; ldw[2] = 32'hFC1E_0000;
        do_load(2'd0, 10'd0, 11'd3, 1'b0, rdy_cyc, done_cyc);
        check("l0.ready_cycles", rdy_cyc, 3);
        check("l0.done_pulses", done_cyc, 1);
        check("l0.count", {21'd0, load_count}, 32'd3);
        do_fetch("k0", 1'b0, 2'd0, 32'd0, 1'b0, 32'h7000_0000);
        do_fetch("k1", 1'b0, 2'd0, 32'd1, 1'b0, 32'h9400_0000);
        do_fetch("k2", 1'b0, 2'd0, 32'd2, 1'b0, 32'hFC1E_0000);
        @(negedge clk);
        check("idle.valid", instr_valid, 1'b0);
        check("idle.hold", instr_out, 32'hFC1E_0000);

        // Wrapping burst into bank 2 with gapped valid.
        ldw[0] = 32'hA000_0001; ldw[1] = 32'hB000_0002; ldw[2] = 32'hC000_0003; ldw[3] = 32'hD000_0004;
        do_load(2'd2, 10'd1022, 11'd4, 1'b1, rdy_cyc, done_cyc);
        check("l2.done_pulses", done_cyc, 1);
        check("l2.count", {21'd0, load_count}, 32'd4);
        do_fetch("u2_0", 1'b1, 2'd2, 32'd0, 1'b0, 32'hC000_0003);
        do_fetch("u2_1022", 1'b1, 2'd2, 32'd1022, 1'b0, 32'hA000_0001);
        do_fetch("u2_1023", 1'b1, 2'd2, 32'd1023, 1'b0, 32'hB000_0002);
        do_fetch("u2_1", 1'b1, 2'd2, 32'd1, 1'b0, 32'hD000_0004);

        // Fetch from the bank under load must fault; bank 0 stays usable.
        @(negedge clk);
        load_start = 1'b1; load_bank = 2'd1; load_base = 10'd0; load_len = 11'd4;
        @(negedge clk);
        load_start = 1'b0;
        check("l1.busy", load_busy, 1'b1);
        check("l1.ready", load_ready, 1'b1);
        do_fetch("u1_busy", 1'b1, 2'd1, 32'd0, 1'b1, 32'd0);
        do_fetch("k_during", 1'b0, 2'd0, 32'd1, 1'b0, 32'h9400_0000);
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data = 32'h1111_0000 + i;
            @(negedge clk);
        end
        load_valid = 1'b0;
        check("l1.done", load_done, 1'b1);
        check("l1.count", {21'd0, load_count}, 32'd4);
        @(negedge clk);
        check("l1.idle", load_busy, 1'b0);
        do_fetch("u1_3", 1'b1, 2'd1, 32'd3, 1'b0, 32'h1111_0003);

        // Address and mode faults.
        do_fetch("f_addr", 1'b0, 2'd0, 32'h0000_0400, 1'b1, 32'd0);
        do_fetch("f_ub0", 1'b1, 2'd0, 32'd0, 1'b1, 32'd0);

        // Zero-length burst completes with no writes.
        do_load(2'd0, 10'd0, 11'd0, 1'b0, rdy_cyc, done_cyc);
        check("l_zero.ready_cycles", rdy_cyc, 0);
        check("l_zero.done_pulses", done_cyc, 1);
        check("l_zero.count", {21'd0, load_count}, 32'd0);
        do_fetch("k0_after_zero", 1'b0, 2'd0, 32'd0, 1'b0, 32'h7000_0000);

        // Reset aborts a 5-word burst after two accepted words.
        @(negedge clk);
        load_start = 1'b1; load_bank = 2'd3; load_base = 10'd5; load_len = 11'd5;
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b1; load_data = 32'hE000_0005;
        @(negedge clk);
        load_data = 32'hF000_0006;
        @(negedge clk);
        load_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort.busy", load_busy, 1'b0);
        check("abort.ready", load_ready, 1'b0);
        check("abort.count", {21'd0, load_count}, 32'd0);
        check("abort.instr_valid", instr_valid, 1'b0);
        check("abort.instr_out", instr_out, 32'd0);
        done_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (load_done) done_cyc++;
            rst = (i < 1);
        end
        check("abort.no_done", done_cyc, 0);
        check("abort.idle", load_busy, 1'b0);
        do_fetch("u3_5", 1'b1, 2'd3, 32'd5, 1'b0, 32'hE000_0005);
        do_fetch("u3_6", 1'b1, 2'd3, 32'd6, 1'b0, 32'hF000_0006);

`ifdef INSTR_MEM_PARITY_EN
        do_fetch("par_ok", 1'b0, 2'd0, 32'd2, 1'b0, 32'hFC1E_0000);
        check("par_ok.err", parity_err, 1'b0);
        dut.mem[0][2][4] = ~dut.mem[0][2][4];
        do_fetch("par_bad", 1'b0, 2'd0, 32'd2, 1'b1, 32'd0);
        check("par_bad.err", parity_err, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/instr_mem_banked.md
Name: instr_mem_banked

Overview:
- Multi-bank instruction memory; next generation of the kernel/user instruction store.
- Bank 0 holds OS code; banks 1..NUM_BANKS-1 hold user process images.
- Provides a registered fetch port to the PC stage with mode- and bounds-based fault checking.
- Provides a handshaked burst loader that writes a program image into a chosen bank at a base offset.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 10, per-bank word address width; depth = 2**ADDR_WIDTH
NUM_BANKS, 4, total banks including OS bank 0
BANK_SEL_WIDTH, 2, width of bank selectors; must satisfy 2**BANK_SEL_WIDTH >= NUM_BANKS

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-high reset
fetch_en  in  1  fetch request this cycle
fetch_addr  in  DATA_WIDTH  word address from PC
mode  in  1  0 = kernel (bank 0), 1 = user (bank user_bank)
user_bank  in  BANK_SEL_WIDTH  bank used in user mode
instr_out  out  DATA_WIDTH  fetched instruction
instr_valid  out  1  instr_out updated by the previous cycle's fetch
fetch_fault  out  1  previous fetch illegal; instr_out = 0
load_start  in  1  begin a load burst (sampled in IDLE only)
load_bank  in  BANK_SEL_WIDTH  target bank
load_base  in  ADDR_WIDTH  first word offset in bank
load_len  in  ADDR_WIDTH+1  words to load, 0..2**ADDR_WIDTH
load_data  in  DATA_WIDTH  word to write
load_valid  in  1  load_data valid
load_ready  out  1  loader accepts a word this cycle
load_busy  out  1  FSM not in IDLE
load_done  out  1  one-cycle pulse at burst completion
load_count  out  ADDR_WIDTH+1  words accepted in current/last burst

Behaviour:
- Reset (async, any time):
  - FSM -> IDLE.
  - instr_out = 0, instr_valid = 0, fetch_fault = 0, load_ready = 0, load_busy = 0, load_done = 0, load_count = 0.
  - Memory contents are not cleared.
- Reset during LOAD aborts the burst:
  - no load_done pulse;
  - words already written remain in memory.
- Fetch path (1-cycle latency):
  - When fetch_en = 1 at posedge, the selected bank is 0 if mode = 0, else user_bank.
  - A fault is raised if any of the following holds:
    - fetch_addr[DATA_WIDTH-1:ADDR_WIDTH] != 0;
    - mode = 1 and user_bank = 0;
    - selected bank >= NUM_BANKS;
    - load_busy = 1 and selected bank = the bank being loaded.
  - Fault: next cycle fetch_fault = 1, instr_out = 0, instr_valid = 1.
  - No fault: next cycle instr_out = mem[bank][fetch_addr[ADDR_WIDTH-1:0]], fetch_fault = 0, instr_valid = 1.
  - When fetch_en = 0: instr_valid = 0, fetch_fault = 0, instr_out holds.
- Loader FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on load_start with load_len != 0 and load_bank < NUM_BANKS.
    - Captures bank, base and len; clears load_count.
  - IDLE -> DONE on load_start with load_len = 0.
  - load_start with load_bank >= NUM_BANKS is ignored; FSM stays in IDLE.
  - LOAD:
    - load_ready = 1.
    - Each cycle with load_valid = 1: write mem[bank][(base + load_count) mod 2**ADDR_WIDTH] = load_data, then load_count += 1.
    - Offset wraps within the bank; there is no spill into the next bank.
    - The transfer completing load_count = len moves the FSM to DONE; load_ready drops in the same edge.
  - DONE: load_done = 1 for one cycle, then IDLE. load_count holds its final value until the next load_start.
  - load_start outside IDLE is ignored; captured parameters do not change mid-burst.
- Load writes and fetch reads to different banks in the same cycle proceed independently.
- Fetch from the bank being loaded faults (see fault list), so there is no read-during-write hazard.

Optional Feature:
INSTR_MEM_PARITY_EN
- Defined:
  - Each word stores one extra even-parity bit, computed at load.
  - On fetch, a parity mismatch forces fetch_fault = 1 and instr_out = 0.
  - Adds output port parity_err (1 bit), high with fetch_fault when parity caused it. Reset value 0.
- Undefined: no parity storage, no parity_err port, fault sources as listed in Behaviour.

Test Plan:
- Reset, then load bank 0 with base 0, len 3, words 0x70000000 / 0x94000000 / 0xFC1E0000, load_valid held high:
  - load_ready high for exactly 3 cycles;
  - load_done pulses once;
  - load_count = 3.
  - Kernel-mode fetch of addresses 0, 1, 2 returns these words one cycle later with instr_valid = 1.
- Load bank 2, base 1022, len 4, load_valid toggled every other cycle:
  - words land at offsets 1022, 1023, 0, 1;
  - user-mode fetch with user_bank = 2 at address 0 returns the 3rd word.
- During an in-progress load to bank 1, user fetch from bank 1 returns fetch_fault = 1 and instr_out = 0.
  - A kernel fetch from bank 0 in the same cycle is unaffected.
- Fault cases: fetch_addr = 0x00000400 -> fault; mode = 1 with user_bank = 0 -> fault.
  - load_start with len = 0 -> load_done on the next cycle, no writes.
- Assert rst after 2 of 5 words in a burst:
  - outputs return to 0, no load_done;
  - the 2 written words are still readable after reset.
- With INSTR_MEM_PARITY_EN defined, force a flipped stored bit via backdoor:
  - fetch gives parity_err = 1, fetch_fault = 1, instr_out = 0.
